// File: rtl/bcd_display_scan.sv
// bcd_display_scan: scans four BCD time digits onto a 4-digit common-anode
// multiplexed 7-segment display. Provides a tear-free per-frame snapshot,
// a blinking colon (dp on digit 2), leading-zero blanking of the hours tens
// digit and a dash for any non-BCD value.
//
// Optional feature macro: BCD_DISPLAY_GHOST_GAP_EN
//   When defined, the first 8 cycles of every digit slot drive all digits
//   off (anti-ghosting dead time). SCAN_DIV must then be at least 16.
//
// Handshake note: this block has no valid/ready interfaces. The digit inputs
// are sampled unconditionally once per frame, on the scan tick that leaves
// digit 3. frame_start is a one-cycle pulse that is high in the cycle in
// which the freshly captured snapshot first becomes visible internally.
module bcd_display_scan #(
  parameter int SCAN_DIV  = 2500,
  parameter int BLINK_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] hora_d,
  input  logic [3:0] hora_u,
  input  logic [3:0] min_d,
  input  logic [3:0] min_u,
  input  logic       blank_lead,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_q, blink_d;
  logic [1:0]    idx_q, idx_d;
  // Snapshot packed as {hora_d, hora_u, min_d, min_u} so digit idx sits at idx*4.
  logic [15:0]   snap_q, snap_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          fs_q, fs_d;

  logic          scan_tick;
  logic          blink_tick;
  logic          load;
  logic [3:0]    cur_digit;

  // Active-low {g,f,e,d,c,b,a} pattern; anything outside 0..9 shows a dash.
  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  // Next-state: dividers, digit index, snapshot and the registered display image.
  always_comb begin
    scan_tick   = (scan_cnt_q == SCAN_LAST);
    scan_cnt_d  = scan_tick ? '0 : scan_cnt_q + SW'(1);
    idx_d       = scan_tick ? idx_q + 2'd1 : idx_q;
    load        = scan_tick && (idx_q == 2'd3);
    snap_d      = load ? {hora_d, hora_u, min_d, min_u} : snap_q;
    fs_d        = load;

    // The colon blink runs on its own divider so a scan tick and a blink
    // toggle landing in the same cycle are simply both applied.
    blink_tick  = (blink_cnt_q == BLINK_LAST);
    blink_cnt_d = blink_tick ? '0 : blink_cnt_q + BW'(1);
    blink_d     = blink_tick ? ~blink_q : blink_q;

    // Display image is built from the current index and snapshot; it lands
    // in the output registers one cycle after idx changes.
    cur_digit   = snap_q[{idx_q, 2'b00} +: 4];
    an_d        = ~(4'b0001 << idx_q);
    seg_d       = decode(cur_digit);
    // blank_lead is deliberately taken live so the option reacts without
    // waiting for the next frame.
    if ((idx_q == 2'd3) && blank_lead && (cur_digit == 4'd0)) begin
      seg_d = 7'b1111111;
    end
    dp_d        = !((idx_q == 2'd2) && blink_q);
`ifdef BCD_DISPLAY_GHOST_GAP_EN
    // Dead time at the start of each slot so the previous digit's segments
    // never bleed into the newly enabled anode.
    if (32'(scan_cnt_q) < 32'd8) begin
      an_d  = 4'b1111;
      seg_d = 7'b1111111;
      dp_d  = 1'b1;
    end
`endif
  end

  // State and output registers, asynchronously cleared to a dark display.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt_q  <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      idx_q       <= 2'd0;
      snap_q      <= 16'h0000;
      an_q        <= 4'b1111;
      seg_q       <= 7'b1111111;
      dp_q        <= 1'b1;
      fs_q        <= 1'b0;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      idx_q       <= idx_d;
      snap_q      <= snap_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      fs_q        <= fs_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// tb_bcd_display_scan: directed, table-driven bench for bcd_display_scan.
// dut1 (SCAN_DIV=4) covers decode, snapshot, blanking and reset behaviour;
// dut2 (SCAN_DIV=2, BLINK_DIV=10) covers colon timing and anode one-hot.
module tb_bcd_display_scan;

  logic       clk;
  logic       rst_n;
  logic [3:0] hora_d, hora_u, min_d, min_u;
  logic       blank_lead;
  logic [3:0] an1, an2;
  logic [6:0] seg1, seg2;
  logic       dp1, dp2, fs1, fs2;

  int n_chk;
  int n_fail;

  typedef struct {
    logic [3:0] hd, hu, md, mu;
    logic       bl;
    logic [6:0] s0, s1, s2, s3;
  } vec_t;

  vec_t vecs[5];

  bcd_display_scan #(.SCAN_DIV(4), .BLINK_DIV(100000)) dut1 (
    .clk(clk), .reset(rst_n),
    .hora_d(hora_d), .hora_u(hora_u), .min_d(min_d), .min_u(min_u),
    .blank_lead(blank_lead),
    .an(an1), .seg(seg1), .dp(dp1), .frame_start(fs1)
  );

  bcd_display_scan #(.SCAN_DIV(2), .BLINK_DIV(10)) dut2 (
    .clk(clk), .reset(rst_n),
    .hora_d(hora_d), .hora_u(hora_u), .min_d(min_d), .min_u(min_u),
    .blank_lead(blank_lead),
    .an(an2), .seg(seg2), .dp(dp2), .frame_start(fs2)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic [3:0] hd, input logic [3:0] hu,
                        input logic [3:0] md, input logic [3:0] mu, input logic bl);
    hora_d = hd; hora_u = hu; min_d = md; min_u = mu; blank_lead = bl;
  endtask

  // One digit slot of dut1: 4 cycles with fixed anode, segments and dark colon.
  task automatic check_slot(input int i, input logic [6:0] es);
    logic [3:0] ea;
    ea = 4'b1111;
    ea[i] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("slot%0d an", i), 32'(an1), 32'(ea));
      chk($sformatf("slot%0d seg", i), 32'(seg1), 32'(es));
      chk($sformatf("slot%0d dp", i), 32'(dp1), 32'd1);
      chk($sformatf("slot%0d frame_start", i), 32'(fs1), 32'((i == 3) && (c == 3)));
    end
  endtask

  task automatic check_frame(input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3);
    check_slot(0, s0);
    check_slot(1, s1);
    check_slot(2, s2);
    check_slot(3, s3);
  endtask

  task automatic wait_fs();
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while ((fs1 !== 1'b1) && (k < 64));
    chk("frame_start seen", 32'(fs1), 32'd1);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;

    //                 hd    hu    md    mu    bl    s0(mu)      s1(md)      s2(hu)      s3(hd)
    vecs[0] = '{4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1111111};
    vecs[1] = '{4'h0, 4'h5, 4'h6, 4'h7, 1'b0, 7'b1111000, 7'b0000010, 7'b0010010, 7'b1000000};
    vecs[2] = '{4'h0, 4'h8, 4'h9, 4'hC, 1'b1, 7'b0111111, 7'b0010000, 7'b0000000, 7'b1111111};
    vecs[3] = '{4'hF, 4'hA, 4'h9, 4'h8, 1'b1, 7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111};
    vecs[4] = '{4'h2, 4'h3, 4'h5, 4'h9, 1'b0, 7'b0010000, 7'b0010010, 7'b0110000, 7'b0100100};

    // Reset hold with 1,2,3,4 presented
    rst_n = 1'b0;
    set_in(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
    repeat (3) step();
    chk("reset an", 32'(an1), 32'hF);
    chk("reset seg", 32'(seg1), 32'h7F);
    chk("reset dp", 32'(dp1), 32'd1);
    chk("reset frame_start", 32'(fs1), 32'd0);
    chk("reset an dut2", 32'(an2), 32'hF);

    // First cycle after release shows digit 0 of the zero snapshot
    rst_n = 1'b1;
    step();
    chk("cycle1 an", 32'(an1), 32'hE);
    chk("cycle1 seg", 32'(seg1), 32'h40);
    chk("cycle1 dp", 32'(dp1), 32'd1);
    chk("cycle1 frame_start", 32'(fs1), 32'd0);

    // First loaded frame displays 4,3,2,1 on an[0..3]
    wait_fs();
    check_frame(7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001);

    // Table of frames
    for (int v = 0; v < 5; v++) begin
      set_in(vecs[v].hd, vecs[v].hu, vecs[v].md, vecs[v].mu, vecs[v].bl);
      wait_fs();
      check_frame(vecs[v].s0, vecs[v].s1, vecs[v].s2, vecs[v].s3);
    end

    // Mid-frame input change: frame keeps 9,5,3,2, following frame is zeros
    set_in(4'd2, 4'd3, 4'd5, 4'd9, 1'b0);
    wait_fs();
    check_slot(0, 7'b0010000);
    set_in(4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    check_slot(1, 7'b0010010);
    check_slot(2, 7'b0110000);
    check_slot(3, 7'b0100100);
    check_frame(7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);

    // Leading blank off on a zero hours tens digit, then on (live)
    set_in(4'd0, 4'd1, 4'd2, 4'd3, 1'b0);
    wait_fs();
    check_frame(7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000);
    blank_lead = 1'b1;
    check_frame(7'b0110000, 7'b0100100, 7'b1111001, 7'b1111111);

    // Reset pulse in the middle of slot 2: immediate dark display, restart at idx 0
    set_in(4'd1, 4'd7, 4'd4, 4'd8, 1'b1);
    wait_fs();
    repeat (10) step();
    rst_n = 1'b0;
    #1;
    chk("async reset an", 32'(an1), 32'hF);
    chk("async reset seg", 32'(seg1), 32'h7F);
    chk("async reset dp", 32'(dp1), 32'd1);
    chk("async reset frame_start", 32'(fs1), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_frame(7'b1000000, 7'b1000000, 7'b1000000, 7'b1111111);

    // Colon timing on dut2 after a fresh reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int n = 1; n <= 80; n++) begin
      int m, ei, ph;
      logic [3:0] ea;
      logic       ed;
      step();
      m  = n - 1;
      ei = (m / 2) % 4;
      ph = (m / 10) % 2;
      ea = 4'b1111;
      ea[ei] = 1'b0;
      ed = !((ei == 2) && (ph == 1));
      chk($sformatf("blink an n=%0d", n), 32'(an2), 32'(ea));
      chk($sformatf("blink dp n=%0d", n), 32'(dp2), 32'(ed));
      chk($sformatf("onehot an n=%0d", n), 32'($countones(~an2)), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
